// File: rtl/histo_readout.sv
// Sweeps every histogram channel, latches its words into shadow registers and streams
// each channel as a framed, checksummed byte sequence over a valid/ready handshake.
module histo_readout #(
  parameter int         NCHAN       = 16,
  parameter int         NHIST       = 8,
  parameter int         MUX_LAT     = 2,
  parameter int         CLEAR_AFTER = 1,
  parameter logic [7:0] HDR         = 8'hA5
) (
  input  logic                   clk_adc,
  input  logic                   rst,
  input  logic                   start,
  output logic [7:0]             histostosend,
  input  logic [NHIST-1:0][31:0] histosout,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   done,
  output logic                   resethist
);

  localparam int WW = (NHIST > 1) ? $clog2(NHIST) : 1;
  localparam int CW = $clog2(MUX_LAT + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_SELECT, S_WAIT, S_LATCH, S_HDR, S_CHAN, S_DATA, S_CSUM, S_FIN
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      ch_q, ch_d;
  logic [7:0]      sel_q, sel_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WW-1:0]   word_q, word_d;
  logic [1:0]      byte_q, byte_d;
  logic [7:0]      csum_q, csum_d;
  logic [31:0]     shadow_q [NHIST];
  logic [31:0]     shadow_d [NHIST];
  logic [31:0]     cur_word;
  logic [7:0]      data_byte;

  // Shadow copy is taken only in LATCH so later histogram updates cannot tear a frame.
  for (genvar gi = 0; gi < NHIST; gi++) begin : g_shadow
    assign shadow_d[gi] = (state_q == S_LATCH) ? histosout[gi] : shadow_q[gi];
    always_ff @(posedge clk_adc) begin
      shadow_q[gi] <= shadow_d[gi];
    end
  end

  assign cur_word  = shadow_q[word_q];
  assign data_byte = cur_word[{byte_q, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    sel_d     = sel_q;
    cnt_d     = cnt_q;
    word_d    = word_q;
    byte_d    = byte_q;
    csum_d    = csum_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    done      = 1'b0;
    resethist = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ch_d    = 8'd0;
          sel_d   = 8'd0;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        sel_d   = ch_q;
        cnt_d   = CW'(MUX_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_LATCH;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_LATCH: begin
        csum_d  = 8'h00;
        word_d  = '0;
        byte_d  = 2'd0;
        state_d = S_HDR;
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR;
        if (tx_ready) state_d = S_CHAN;
      end
      S_CHAN: begin
        tx_valid = 1'b1;
        tx_data  = ch_q;
        if (tx_ready) begin
          csum_d  = csum_q ^ ch_q;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
        if (tx_ready) begin
          csum_d = csum_q ^ data_byte;
          if (byte_q == 2'd3) begin
            byte_d = 2'd0;
            if (word_q == WW'(NHIST - 1)) state_d = S_CSUM;
            else                          word_d  = word_q + 1'b1;
          end else begin
            byte_d = byte_q + 1'b1;
          end
        end
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) begin
          if (ch_q == 8'(NCHAN - 1)) begin
            state_d = S_FIN;
          end else begin
            ch_d    = ch_q + 8'd1;
            state_d = S_SELECT;
          end
        end
      end
      S_FIN: begin
        done      = 1'b1;
        resethist = (CLEAR_AFTER != 0);
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_adc) begin
    if (rst) begin
      state_q <= S_IDLE;
      ch_q    <= 8'd0;
      sel_q   <= 8'd0;
      cnt_q   <= '0;
      word_q  <= '0;
      byte_q  <= 2'd0;
      csum_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
    end
  end

  assign histostosend = sel_q;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_histo_readout.sv
// Directed bench for histo_readout: framing, latency, backpressure, checksum,
// start/reset robustness and shadow isolation; a second instance has clearing disabled.
module tb_histo_readout;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            tx_ready = 1'b1;
  logic [7:0][31:0] histosout;
  logic [7:0]      hsel, hsel0;
  logic [7:0]      tx_data, tx_data0;
  logic            tx_valid, tx_valid0;
  logic            busy, busy0, done, done0, resethist, resethist0;
  int              mode = 0;

  int n_pass = 0;
  int n_checks = 0;
  int done_cnt = 0, done0_cnt = 0, rh_cnt = 0, rh0_cnt = 0, stall_err = 0;
  logic [7:0] bytes[$];
  logic       stall_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  always #5 clk = ~clk;

  histo_readout #(.CLEAR_AFTER(1)) u_dut (
    .clk_adc(clk), .rst(rst), .start(start), .histostosend(hsel), .histosout(histosout),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done), .resethist(resethist));

  histo_readout #(.CLEAR_AFTER(0)) u_dut0 (
    .clk_adc(clk), .rst(rst), .start(start), .histostosend(hsel0), .histosout(histosout),
    .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
    .busy(busy0), .done(done0), .resethist(resethist0));

  // Histogram source: 0 = 0x01020300+k everywhere, 1 = channel 3 all ones, 2 = all 0xDEADBEEF
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      case (mode)
        1:       histosout[k] = (hsel == 8'd3) ? 32'hFFFF_FFFF : 32'h0102_0300 + k;
        2:       histosout[k] = 32'hDEAD_BEEF;
        default: histosout[k] = 32'h0102_0300 + k;
      endcase
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) bytes.push_back(tx_data);
      if (stall_prev && tx_valid && tx_data !== data_prev) stall_err++;
      if (done) done_cnt++;
      if (done0) done0_cnt++;
      if (resethist) rh_cnt++;
      if (resethist0) rh0_cnt++;
    end
    stall_prev = tx_valid && !tx_ready && !rst;
    data_prev  = tx_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Hand-derived frame content; the checksum always equals the channel number because
  // each data word contributes an even number of identical byte patterns or cancels.
  function automatic logic [7:0] exp_byte(input int f, input int i, input int m);
    int k, b;
    logic [31:0] w;
    logic [7:0]  fb;
    fb = f[7:0];
    if (i == 0)  return 8'hA5;
    if (i == 1)  return fb;
    if (i == 34) return fb;
    k = (i - 2) / 4;
    b = (i - 2) % 4;
    if (m == 1 && f == 3)     w = 32'hFFFF_FFFF;
    else if (m == 2 && f > 0) w = 32'hDEAD_BEEF;
    else                      w = 32'h0102_0300 + k;
    return w[8*b +: 8];
  endfunction

  task automatic check_stream(input string name, input int base, input int m);
    check({name, "_len"}, bytes.size() - base, 560);
    if (bytes.size() - base >= 560) begin
      for (int f = 0; f < 16; f++)
        for (int i = 0; i < 35; i++)
          check($sformatf("%s_f%0d_b%0d", name, f, i), bytes[base + f*35 + i], exp_byte(f, i, m));
    end
  endtask

  task automatic wait_done(input string name, input bit rnd);
    bit seen = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
    end
    check({name, "_done_seen"}, seen, 1);
    check({name, "_resethist"}, resethist, 1);
    check({name, "_done_nc"}, done0, 1);
    check({name, "_resethist_nc"}, resethist0, 0);
    tx_ready = 1'b1;
    @(negedge clk);
    check({name, "_idle_busy"}, busy, 0);
    check({name, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int base, d0, r0, s0;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_resethist", resethist, 0);
    check("rst_histostosend", hsel, 0);
    rst = 1'b0;
    @(negedge clk);
    tx_ready = 1'b1;
    check("idle_ready_no_valid", tx_valid, 0);

    // Tests 1+2: full dump with constant ready, latency of first byte
    base = bytes.size(); d0 = done_cnt; r0 = rh_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("lat_busy_t1", busy, 1);
    check("lat_valid_t1", tx_valid, 0);
    @(negedge clk);
    check("lat_sel_t2", hsel, 0);
    repeat (2) @(negedge clk);
    check("lat_valid_t4", tx_valid, 0);
    @(negedge clk);
    check("lat_valid_t5", tx_valid, 1);
    check("lat_hdr_t5", tx_data, 8'hA5);
    wait_done("t1", 1'b0);
    check_stream("t1", base, 0);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_rh_cnt", rh_cnt - r0, 1);

    // Test 3: random backpressure, same stream, stable data while stalled
    base = bytes.size(); s0 = stall_err;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t3", 1'b1);
    check_stream("t3", base, 0);
    check("t3_stall_stable", stall_err - s0, 0);

    // Test 4: channel 3 all ones -> checksum 0x03
    mode = 1; base = bytes.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4", 1'b0);
    check_stream("t4", base, 1);
    check("t4_csum_ch3", bytes[base + 3*35 + 34], 8'h03);
    mode = 0;

    // Test 5a: start during dump is ignored
    base = bytes.size(); d0 = done_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t5", 1'b0);
    repeat (40) @(negedge clk);
    check_stream("t5", base, 0);
    check("t5_done_cnt", done_cnt - d0, 1);

    // Test 5b: reset in the middle of a frame aborts the dump
    d0 = done_cnt; r0 = rh_cnt;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("t5r_valid_before", tx_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5r_valid", tx_valid, 0);
    check("t5r_busy", busy, 0);
    check("t5r_sel", hsel, 0);
    check("t5r_done", done, 0);
    check("t5r_resethist", resethist, 0);
    repeat (100) @(negedge clk);
    check("t5r_still_idle", busy, 0);
    check("t5r_no_done", done_cnt - d0, 0);
    check("t5r_no_rh", rh_cnt - r0, 0);

    // Test 6: histosout changes right after the first frame is latched
    base = bytes.size();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && tx_valid !== 1'b1; c++) @(negedge clk);
    check("t6_first_valid", tx_valid, 1);
    mode = 2;
    wait_done("t6", 1'b0);
    check_stream("t6", base, 2);
    mode = 0;

    check("nc_resethist_never", rh0_cnt, 0);
    check("nc_done_matches", done0_cnt, done_cnt);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
